timekeeper_mode_ctrl: RTL and testbench
=======================================

Name: timekeeper_mode_ctrl

Overview:
- Control sequencer for the clock/stopwatch/alarm timekeeping datapath that feeds the VGA time display.
- Conditions raw push-buttons: 2-FF synchroniser, debounce, rising-edge detect.
- Runs the mode state machine and generates the 1 Hz tick prescaler.
- Issues one-cycle increment/clear strobes and enable levels to the hour/min/sec counters, plus a blink level for the display.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1, tick rate; prescaler period P = CLK_HZ/TICK_HZ cycles (P even, P>=4).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles D required to accept a button level (D>=1).

Ports:
- clk_100MHz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- hour_in, min_in, sec_in, mode_in, start_stop  in  1 each  raw asynchronous buttons, active-high.
- mode  out  2  current mode: 00 CLOCK, 01 SET_TIME, 10 STOPWATCH, 11 SET_ALARM.
- tick_1hz  out  1  one-cycle pulse every P cycles, free-running.
- clk_en  out  1  time-of-day count enable.
- set_hour, set_min, set_sec  out  1 each  one-cycle time-of-day increment strobes.
- alm_hour, alm_min, alm_sec  out  1 each  one-cycle alarm increment strobes.
- sw_run  out  1  stopwatch running level.
- sw_en  out  1  stopwatch count enable.
- sw_clear  out  1  one-cycle stopwatch clear strobe.
- blink  out  1  display blink level for the field being set.

Behaviour:
- Reset (synchronous, any cycle, including mid-operation):
  - mode=CLOCK; all outputs 0.
  - Prescaler count=0.
  - Debouncer accepted levels=0 and counters=0.
  - A button still held when reset releases produces a press, D+3 cycles later.
- Button path:
  - 2-FF synchroniser, then debouncer.
  - Debouncer counter increments while the synced level differs from the accepted level.
  - Any cycle where they match clears the counter.
  - When the counter reaches D, the accepted level updates.
  - press = accepted & ~accepted_d, exactly one cycle wide.
  - Latency: an input held high from cycle N gives press in cycle N+D+3. Glitches shorter than D cycles give no press.
  - Release produces no event.
- Prescaler:
  - Counts 0..P-1 and wraps.
  - tick_1hz is asserted (registered) in the cycle after count=P-1; first tick in cycle P after reset release.
  - blink is registered and equals 1 while count >= P/2.
  - On entry to SET_TIME the prescaler is cleared to 0.
- Mode FSM, advanced by a mode_in press: CLOCK -> SET_TIME -> STOPWATCH -> SET_ALARM -> CLOCK.
- Priority: a mode_in press in the same cycle as any other press wins. Other presses in that cycle are discarded, and no strobe is emitted for that cycle.
- Per-mode actions (strobes are registered, one cycle after the press cycle):
  - CLOCK: hour/min/sec/start_stop presses ignored.
  - SET_TIME: hour_in -> set_hour, min_in -> set_min, sec_in -> set_sec. start_stop ignored.
  - STOPWATCH: start_stop toggles sw_run. hour_in -> sw_clear pulse and sw_run<=0 in the same cycle. min_in/sec_in ignored.
  - SET_ALARM: hour_in -> alm_hour, min_in -> alm_min, sec_in -> alm_sec. start_stop ignored.
  - Simultaneous non-mode presses each produce their own strobe in the same cycle.
  - STOPWATCH exception: hour_in (clear) beats start_stop; sw_run ends 0.
- Enables:
  - clk_en = tick_1hz while mode != SET_TIME; asserted in the same cycle as tick_1hz.
  - sw_en = tick_1hz & sw_run, in all modes (stopwatch keeps running in background).
- sw_run persists across mode changes. It is cleared only by reset, by a clear, or by a start_stop toggle.
- No strobe is ever wider than one cycle. Strobes are mutually independent registers.

Test Plan:
(CLK_HZ=20, TICK_HZ=1, DEBOUNCE_CYCLES=4 → P=20)
- Reset released, no buttons -> tick_1hz and clk_en high in cycles 20, 40, 60; blink high in cycles 11–20; mode=00.
- mode_in held high from cycle 100 -> press at cycle 107, mode=01 from 108. Prescaler cleared, clk_en stays 0 on subsequent ticks. Three more presses give mode 10, 11, 00.
- In SET_TIME, min_in high 3 cycles then low -> no strobe. Held 10 cycles -> exactly one set_min pulse; set_hour/set_sec stay 0.
- In STOPWATCH, start_stop press -> sw_run=1 and sw_en pulses on ticks. Switch to SET_ALARM: sw_en continues. Back to STOPWATCH, hour_in press -> sw_clear one cycle, sw_run=0.
- In STOPWATCH, hour_in and start_stop presses in the same cycle -> sw_clear=1, sw_run=0. mode_in with min_in in the same cycle while in SET_ALARM -> mode=00, no alm_min.
- reset asserted while sw_run=1 in STOPWATCH with a button held -> next cycle mode=00, sw_run=0. Press reappears D+3 cycles after reset release.

Source files
------------

// File: rtl/timekeeper_mode_ctrl.sv
// Mode sequencer for the timekeeping datapath: button conditioning, mode FSM,
// 1 Hz prescaler and the increment/clear strobes and enables for the counters.
module timekeeper_mode_ctrl #(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       hour_in,
    input  logic       min_in,
    input  logic       sec_in,
    input  logic       mode_in,
    input  logic       start_stop,
    output logic [1:0] mode,
    output logic       tick_1hz,
    output logic       clk_en,
    output logic       set_hour,
    output logic       set_min,
    output logic       set_sec,
    output logic       alm_hour,
    output logic       alm_min,
    output logic       alm_sec,
    output logic       sw_run,
    output logic       sw_en,
    output logic       sw_clear,
    output logic       blink
);

    localparam int P    = CLK_HZ / TICK_HZ;
    localparam int CW   = $clog2(P);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NBTN = 5;

    localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(P / 2);
    localparam logic [DW-1:0] DB_LIMIT = DW'(DEBOUNCE_CYCLES);

    localparam int B_HOUR = 0;
    localparam int B_MIN  = 1;
    localparam int B_SEC  = 2;
    localparam int B_MODE = 3;
    localparam int B_SS   = 4;

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'b00,
        ST_SET_TIME  = 2'b01,
        ST_STOPWATCH = 2'b10,
        ST_SET_ALARM = 2'b11
    } mode_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] press;

    assign btn_raw = {start_stop, mode_in, sec_in, min_in, hour_in};

    // Per button: 2-FF synchroniser, counting debouncer, rising-edge detect.
    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          level_d_reg;
            logic [DW-1:0] stable_cnt_reg;

            always_ff @(posedge clk_100MHz) begin
                if (reset) begin
                    sync1_reg      <= 1'b0;
                    sync2_reg      <= 1'b0;
                    level_reg      <= 1'b0;
                    level_d_reg    <= 1'b0;
                    stable_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    if (sync2_reg == level_reg) begin
                        stable_cnt_reg <= '0;
                    end else if (stable_cnt_reg == DB_LIMIT) begin
                        level_reg      <= sync2_reg;
                        stable_cnt_reg <= '0;
                    end else begin
                        stable_cnt_reg <= stable_cnt_reg + DW'(1);
                    end
                end
            end

            assign press[gi] = level_reg & ~level_d_reg;
        end
    endgenerate

    mode_t   state_reg, state_next;
    logic    set_hour_reg, set_hour_next;
    logic    set_min_reg, set_min_next;
    logic    set_sec_reg, set_sec_next;
    logic    alm_hour_reg, alm_hour_next;
    logic    alm_min_reg, alm_min_next;
    logic    alm_sec_reg, alm_sec_next;
    logic    sw_clear_reg, sw_clear_next;
    logic    sw_run_reg, sw_run_next;
    logic    presc_clear;

    logic [CW-1:0] presc_cnt_reg;
    logic          tick_reg;
    logic          blink_reg;

    always_comb begin
        state_next    = state_reg;
        set_hour_next = 1'b0;
        set_min_next  = 1'b0;
        set_sec_next  = 1'b0;
        alm_hour_next = 1'b0;
        alm_min_next  = 1'b0;
        alm_sec_next  = 1'b0;
        sw_clear_next = 1'b0;
        sw_run_next   = sw_run_reg;
        presc_clear   = 1'b0;

        // A mode press swallows every other press arriving in the same cycle.
        if (press[B_MODE]) begin
            case (state_reg)
                ST_CLOCK: begin
                    state_next  = ST_SET_TIME;
                    presc_clear = 1'b1;
                end
                ST_SET_TIME:  state_next = ST_STOPWATCH;
                ST_STOPWATCH: state_next = ST_SET_ALARM;
                default:      state_next = ST_CLOCK;
            endcase
        end else begin
            case (state_reg)
                ST_SET_TIME: begin
                    set_hour_next = press[B_HOUR];
                    set_min_next  = press[B_MIN];
                    set_sec_next  = press[B_SEC];
                end
                ST_STOPWATCH: begin
                    if (press[B_HOUR]) begin
                        sw_clear_next = 1'b1;
                        sw_run_next   = 1'b0;
                    end else if (press[B_SS]) begin
                        sw_run_next = ~sw_run_reg;
                    end
                end
                ST_SET_ALARM: begin
                    alm_hour_next = press[B_HOUR];
                    alm_min_next  = press[B_MIN];
                    alm_sec_next  = press[B_SEC];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_reg    <= ST_CLOCK;
            set_hour_reg <= 1'b0;
            set_min_reg  <= 1'b0;
            set_sec_reg  <= 1'b0;
            alm_hour_reg <= 1'b0;
            alm_min_reg  <= 1'b0;
            alm_sec_reg  <= 1'b0;
            sw_clear_reg <= 1'b0;
            sw_run_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            set_hour_reg <= set_hour_next;
            set_min_reg  <= set_min_next;
            set_sec_reg  <= set_sec_next;
            alm_hour_reg <= alm_hour_next;
            alm_min_reg  <= alm_min_next;
            alm_sec_reg  <= alm_sec_next;
            sw_clear_reg <= sw_clear_next;
            sw_run_reg   <= sw_run_next;
        end
    end

    // Free-running prescaler, realigned when time setting begins.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            presc_cnt_reg <= '0;
            tick_reg      <= 1'b0;
            blink_reg     <= 1'b0;
        end else begin
            tick_reg  <= (presc_cnt_reg == CNT_LAST);
            blink_reg <= (presc_cnt_reg >= CNT_HALF);
            if (presc_clear || (presc_cnt_reg == CNT_LAST)) begin
                presc_cnt_reg <= '0;
            end else begin
                presc_cnt_reg <= presc_cnt_reg + CW'(1);
            end
        end
    end

    assign mode     = state_reg;
    assign tick_1hz = tick_reg;
    assign clk_en   = tick_reg && (state_reg != ST_SET_TIME);
    assign sw_en    = tick_reg && sw_run_reg;
    assign blink    = blink_reg;
    assign set_hour = set_hour_reg;
    assign set_min  = set_min_reg;
    assign set_sec  = set_sec_reg;
    assign alm_hour = alm_hour_reg;
    assign alm_min  = alm_min_reg;
    assign alm_sec  = alm_sec_reg;
    assign sw_run   = sw_run_reg;
    assign sw_clear = sw_clear_reg;

endmodule

// File: tb/tb_timekeeper_mode_ctrl.sv
// Directed bench for timekeeper_mode_ctrl with P=20, D=4; cycle 0 is the first
// cycle after the last reset edge, inputs change and outputs are checked 1 ns after each edge.
module tb_timekeeper_mode_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset      = 1'b1;
    logic       hour_in    = 1'b0;
    logic       min_in     = 1'b0;
    logic       sec_in     = 1'b0;
    logic       mode_in    = 1'b0;
    logic       start_stop = 1'b0;
    logic [1:0] mode;
    logic       tick_1hz, clk_en, set_hour, set_min, set_sec;
    logic       alm_hour, alm_min, alm_sec, sw_run, sw_en, sw_clear, blink;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int set_min_n  = 0;
    int set_hour_n = 0;
    int set_sec_n  = 0;
    int min_snap, hour_snap, sec_snap;

    timekeeper_mode_ctrl #(
        .CLK_HZ(20),
        .TICK_HZ(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .hour_in(hour_in),
        .min_in(min_in),
        .sec_in(sec_in),
        .mode_in(mode_in),
        .start_stop(start_stop),
        .mode(mode),
        .tick_1hz(tick_1hz),
        .clk_en(clk_en),
        .set_hour(set_hour),
        .set_min(set_min),
        .set_sec(set_sec),
        .alm_hour(alm_hour),
        .alm_min(alm_min),
        .alm_sec(alm_sec),
        .sw_run(sw_run),
        .sw_en(sw_en),
        .sw_clear(sw_clear),
        .blink(blink)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    always @(negedge clk_100MHz) begin
        if (set_min)  set_min_n++;
        if (set_hour) set_hour_n++;
        if (set_sec)  set_sec_n++;
    end

    task automatic go(input int target);
        while (cyc < target) begin
            @(posedge clk_100MHz);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_100MHz);
        #1;
        reset = 1'b0;
        cyc   = 0;

        $display("step cyc=%0d reset state", cyc);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_tick", 32'(tick_1hz), 0);
        chk("rst_clk_en", 32'(clk_en), 0);
        chk("rst_blink", 32'(blink), 0);
        chk("rst_sw_run", 32'(sw_run), 0);
        chk("rst_sw_en", 32'(sw_en), 0);
        chk("rst_strobes", 32'({set_hour, set_min, set_sec, alm_hour, alm_min, alm_sec, sw_clear}), 0);

        $display("step cyc=%0d prescaler free run", cyc);
        go(10);  chk("blink_c10", 32'(blink), 0);
        go(11);  chk("blink_c11", 32'(blink), 1);
        go(19);  chk("tick_c19", 32'(tick_1hz), 0);
        go(20);  chk("tick_c20", 32'(tick_1hz), 1);
                 chk("clk_en_c20", 32'(clk_en), 1);
                 chk("blink_c20", 32'(blink), 1);
        go(21);  chk("tick_c21", 32'(tick_1hz), 0);
                 chk("blink_c21", 32'(blink), 0);
        go(40);  chk("tick_c40", 32'(tick_1hz), 1);
                 chk("clk_en_c40", 32'(clk_en), 1);
        go(60);  chk("tick_c60", 32'(tick_1hz), 1);
                 chk("mode_c60", 32'(mode), 0);

        $display("step cyc=%0d mode press into SET_TIME", cyc);
        go(100); mode_in = 1'b1;
        go(107); chk("mode_c107", 32'(mode), 0);
        go(108); chk("mode_c108", 32'(mode), 1);
        go(110); mode_in = 1'b0;
        go(118); chk("blink_c118", 32'(blink), 0);
        go(119); chk("blink_c119", 32'(blink), 1);
        go(120); chk("tick_c120_cleared", 32'(tick_1hz), 0);
        go(127); chk("tick_c127", 32'(tick_1hz), 0);
        go(128); chk("tick_c128", 32'(tick_1hz), 1);
                 chk("clk_en_c128_settime", 32'(clk_en), 0);

        $display("step cyc=%0d min_in glitch", cyc);
        go(140); min_snap = set_min_n; min_in = 1'b1;
        go(143); min_in = 1'b0;
        go(160); chk("glitch_no_set_min", 32'(set_min_n - min_snap), 0);

        $display("step cyc=%0d min_in held", cyc);
        min_snap  = set_min_n;
        hour_snap = set_hour_n;
        sec_snap  = set_sec_n;
        min_in    = 1'b1;
        go(167); chk("set_min_c167", 32'(set_min), 0);
        go(168); chk("set_min_c168", 32'(set_min), 1);
                 chk("set_hs_c168", 32'({set_hour, set_sec}), 0);
                 chk("clk_en_c168", 32'(clk_en), 0);
        go(169); chk("set_min_c169", 32'(set_min), 0);
        go(170); min_in = 1'b0;
        go(199); chk("set_min_count", 32'(set_min_n - min_snap), 1);
                 chk("set_hour_count", 32'(set_hour_n - hour_snap), 0);
                 chk("set_sec_count", 32'(set_sec_n - sec_snap), 0);

        $display("step cyc=%0d enter STOPWATCH and start", cyc);
        go(200); mode_in = 1'b1;
        go(208); chk("mode_c208", 32'(mode), 2);
        go(210); mode_in = 1'b0;
        go(220); start_stop = 1'b1;
        go(227); chk("sw_run_c227", 32'(sw_run), 0);
        go(228); chk("sw_run_c228", 32'(sw_run), 1);
                 chk("sw_en_c228", 32'(sw_en), 1);
                 chk("clk_en_c228", 32'(clk_en), 1);
        go(230); start_stop = 1'b0;
        go(245); chk("sw_run_release", 32'(sw_run), 1);
        go(247); chk("sw_en_c247", 32'(sw_en), 0);
        go(248); chk("sw_en_c248", 32'(sw_en), 1);

        $display("step cyc=%0d SET_ALARM background stopwatch", cyc);
        go(250); mode_in = 1'b1;
        go(258); chk("mode_c258", 32'(mode), 3);
        go(260); mode_in = 1'b0;
        go(268); chk("sw_en_c268_alarm", 32'(sw_en), 1);
                 chk("sw_run_c268", 32'(sw_run), 1);

        $display("step cyc=%0d alarm hour+sec together", cyc);
        go(270); hour_in = 1'b1; sec_in = 1'b1;
        go(277); chk("alm_c277", 32'({alm_hour, alm_min, alm_sec}), 0);
        go(278); chk("alm_c278", 32'({alm_hour, alm_min, alm_sec}), 3'b101);
                 chk("sw_clear_c278", 32'(sw_clear), 0);
                 chk("sw_run_c278", 32'(sw_run), 1);
                 chk("set_hour_c278", 32'(set_hour), 0);
        go(279); chk("alm_c279", 32'({alm_hour, alm_min, alm_sec}), 0);
        go(280); hour_in = 1'b0; sec_in = 1'b0;

        $display("step cyc=%0d mode+min together in SET_ALARM", cyc);
        go(290); mode_in = 1'b1; min_in = 1'b1;
        go(297); chk("mode_c297", 32'(mode), 3);
        go(298); chk("mode_c298", 32'(mode), 0);
                 chk("alm_min_c298", 32'(alm_min), 0);
                 chk("sw_run_c298", 32'(sw_run), 1);
        go(299); chk("alm_min_c299", 32'(alm_min), 0);
        go(300); mode_in = 1'b0; min_in = 1'b0;

        $display("step cyc=%0d back to STOPWATCH", cyc);
        go(310); mode_in = 1'b1;
        go(318); chk("mode_c318", 32'(mode), 1);
        go(320); mode_in = 1'b0;
        go(330); mode_in = 1'b1;
        go(338); chk("mode_c338", 32'(mode), 2);
                 chk("tick_c338", 32'(tick_1hz), 1);
                 chk("clk_en_c338", 32'(clk_en), 1);
                 chk("sw_en_c338", 32'(sw_en), 1);
        go(340); mode_in = 1'b0;

        $display("step cyc=%0d stopwatch clear", cyc);
        go(350); hour_in = 1'b1;
        go(357); chk("sw_run_c357", 32'(sw_run), 1);
                 chk("sw_clear_c357", 32'(sw_clear), 0);
        go(358); chk("sw_clear_c358", 32'(sw_clear), 1);
                 chk("sw_run_c358", 32'(sw_run), 0);
                 chk("tick_c358", 32'(tick_1hz), 1);
                 chk("sw_en_c358", 32'(sw_en), 0);
        go(359); chk("sw_clear_c359", 32'(sw_clear), 0);
        go(360); hour_in = 1'b0;

        $display("step cyc=%0d clear beats start_stop", cyc);
        go(370); hour_in = 1'b1; start_stop = 1'b1;
        go(377); chk("sw_clear_c377", 32'(sw_clear), 0);
        go(378); chk("sw_clear_c378", 32'(sw_clear), 1);
                 chk("sw_run_c378", 32'(sw_run), 0);
        go(379); chk("sw_clear_c379", 32'(sw_clear), 0);
                 chk("sw_run_c379", 32'(sw_run), 0);
        go(380); hour_in = 1'b0; start_stop = 1'b0;

        $display("step cyc=%0d restart stopwatch", cyc);
        go(390); start_stop = 1'b1;
        go(397); chk("sw_run_c397", 32'(sw_run), 0);
        go(398); chk("sw_run_c398", 32'(sw_run), 1);
                 chk("sw_en_c398", 32'(sw_en), 1);
        go(400); start_stop = 1'b0;
        go(418); chk("sw_run_c418", 32'(sw_run), 1);

        $display("step cyc=%0d reset with mode_in held", cyc);
        go(430); mode_in = 1'b1;
        go(433); reset = 1'b1;
        go(434); chk("mode_after_rst", 32'(mode), 0);
                 chk("sw_run_after_rst", 32'(sw_run), 0);
                 chk("blink_after_rst", 32'(blink), 0);
                 chk("tick_after_rst", 32'(tick_1hz), 0);
        go(435); reset = 1'b0;
        go(438); chk("mode_c438", 32'(mode), 0);
        go(442); chk("mode_c442", 32'(mode), 0);
        go(443); chk("mode_c443", 32'(mode), 1);
        go(445); mode_in = 1'b0;
        go(460);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
